// File: rtl/dcache_wb_buffer.sv
// Write-back buffer: a small FIFO of evicted dirty lines that drains to memory over req/ack.
// Lookups on a dcache miss return pending line data so stale memory is never read.
module dcache_wb_buffer #(
  parameter int DEPTH       = 4,
  parameter int LINE_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 32,
  parameter int OFFSET_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_req_i,
  input  logic [ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [LINE_WIDTH-1:0] wb_data_i,
  output logic                  wb_ack_o,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [ADDR_WIDTH-1:0] lkup_addr_i,
  output logic                  lkup_hit_o,
  output logic [LINE_WIDTH-1:0] lkup_data_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [LINE_WIDTH-1:0] mem_data_o,
  input  logic                  mem_ack_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = ADDR_WIDTH - OFFSET_BITS;

  typedef enum logic {IDLE, REQ} state_t;

  // Handshakes: wb side is held by the dcache until wb_ack_o; a line moves to memory
  // on the cycle mem_req_o and mem_ack_i are both high, and mem_req_o/addr/data stay
  // stable until then.
  state_t                state;
  logic [DEPTH-1:0]      valid;
  logic [TW-1:0]         tag  [DEPTH];
  logic [LINE_WIDTH-1:0] data [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  logic [TW-1:0] wb_tag;
  logic [TW-1:0] lk_tag;
  logic          head_locked;
  logic          merge_hit;
  logic [PW-1:0] merge_idx;
  logic          merge;
  logic          push;
  logic          pop;
  logic          head_match;
  logic          tail_hit;
  logic [LINE_WIDTH-1:0] tail_data;
  logic          unused_offset;

  assign wb_tag = wb_addr_i[ADDR_WIDTH-1:OFFSET_BITS];
  assign lk_tag = lkup_addr_i[ADDR_WIDTH-1:OFFSET_BITS];
  assign unused_offset = ^{wb_addr_i[OFFSET_BITS-1:0], lkup_addr_i[OFFSET_BITS-1:0]};

  // Whenever the buffer is non-empty the head is either in flight or being captured
  // into the memory registers this cycle, so it must never be merged into.
  assign head_locked = (count != '0);

  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (tag[i] == wb_tag) && !(head_locked && (PW'(i) == rd_ptr))) begin
        merge_hit = 1'b1;
        merge_idx = PW'(i);
      end
    end
  end

  assign full_o   = (count == CW'(DEPTH));
  assign empty_o  = (count == '0) && (state == IDLE);
  assign merge    = wb_req_i & merge_hit;
  assign push     = wb_req_i & ~merge_hit & ~full_o;
  assign wb_ack_o = merge | push;
  assign pop      = (state == REQ) & mem_ack_i;

  // Duplicates exist only between the head and one younger entry; the younger one is newer.
  always_comb begin
    head_match = valid[rd_ptr] && (tag[rd_ptr] == lk_tag);
    tail_hit   = 1'b0;
    tail_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (tag[i] == lk_tag) && (PW'(i) != rd_ptr)) begin
        tail_hit  = 1'b1;
        tail_data = data[i];
      end
    end
    lkup_hit_o  = tail_hit | head_match;
    lkup_data_o = tail_hit ? tail_data : (head_match ? data[rd_ptr] : '0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag[wr_ptr]  <= wb_tag;
      data[wr_ptr] <= wb_data_i;
    end else if (merge) begin
      data[merge_idx] <= wb_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= IDLE;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else begin
      if (push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);

      case (state)
        IDLE: begin
          if (count != '0) begin
            mem_addr_o <= {tag[rd_ptr], {OFFSET_BITS{1'b0}}};
            mem_data_o <= data[rd_ptr];
            mem_req_o  <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          mem_req_o <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Bench for dcache_wb_buffer: per-cycle vector tables for basic drain and full/backpressure,
// then hand-written sequences for merge, re-push of an in-flight line, lookup timing and reset.
module tb_dcache_wb_buffer;

  logic         clk;
  logic         rst;
  logic         wb_req;
  logic [31:0]  wb_addr;
  logic [127:0] wb_data;
  logic         wb_ack;
  logic         full;
  logic         empty;
  logic [31:0]  lkup_addr;
  logic         lkup_hit;
  logic [127:0] lkup_data;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic [127:0] mem_data;
  logic         mem_ack;

  int checks;
  int failures;

  localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] B1 = {16{8'hB1}};
  localparam logic [127:0] B2 = {16{8'hB2}};
  localparam logic [127:0] B3 = {16{8'hB3}};
  localparam logic [127:0] B4 = {16{8'hB4}};
  localparam logic [127:0] B5 = {16{8'hB5}};
  localparam logic [127:0] C1 = {8{16'hC001}};
  localparam logic [127:0] C2 = {8{16'hC002}};
  localparam logic [127:0] C3 = {8{16'hC003}};
  localparam logic [127:0] E1 = {4{32'hE111_0001}};
  localparam logic [127:0] E2 = {4{32'hE222_0002}};
  localparam logic [127:0] F5 = {4{32'hF555_5555}};
  localparam logic [127:0] G1 = {4{32'h7777_0001}};

  typedef struct {
    logic         req;
    logic [31:0]  waddr;
    logic [127:0] wdata;
    logic [31:0]  laddr;
    logic         ack;
    logic         e_ack;
    logic         e_full;
    logic         e_empty;
    logic         e_req;
    logic [31:0]  e_maddr;
    logic [127:0] e_mdata;
    logic         e_hit;
    logic [127:0] e_ldata;
  } vec_t;

  vec_t vecs[$];

  dcache_wb_buffer #(
    .DEPTH(4), .LINE_WIDTH(128), .ADDR_WIDTH(32), .OFFSET_BITS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_req_i(wb_req), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .wb_ack_o(wb_ack),
    .full_o(full), .empty_o(empty),
    .lkup_addr_i(lkup_addr), .lkup_hit_o(lkup_hit), .lkup_data_o(lkup_data),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_ack_i(mem_ack)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic [31:0] addr, input logic [127:0] dat,
                       input logic [31:0] lk, input logic ack);
    wb_req    = req;
    wb_addr   = addr;
    wb_data   = dat;
    lkup_addr = lk;
    mem_ack   = ack;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic req, input logic [31:0] waddr, input logic [127:0] wdata,
                         input logic [31:0] laddr, input logic ack,
                         input logic e_ack, input logic e_full, input logic e_empty,
                         input logic e_req, input logic [31:0] e_maddr, input logic [127:0] e_mdata,
                         input logic e_hit, input logic [127:0] e_ldata);
    vec_t v;
    v.req = req; v.waddr = waddr; v.wdata = wdata; v.laddr = laddr; v.ack = ack;
    v.e_ack = e_ack; v.e_full = e_full; v.e_empty = e_empty; v.e_req = e_req;
    v.e_maddr = e_maddr; v.e_mdata = e_mdata; v.e_hit = e_hit; v.e_ldata = e_ldata;
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input string tname);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].req, vecs[i].waddr, vecs[i].wdata, vecs[i].laddr, vecs[i].ack);
      #1;
      chk($sformatf("%s[%0d].wb_ack", tname, i), 128'(wb_ack), 128'(vecs[i].e_ack));
      chk($sformatf("%s[%0d].full", tname, i), 128'(full), 128'(vecs[i].e_full));
      chk($sformatf("%s[%0d].empty", tname, i), 128'(empty), 128'(vecs[i].e_empty));
      chk($sformatf("%s[%0d].mem_req", tname, i), 128'(mem_req), 128'(vecs[i].e_req));
      chk($sformatf("%s[%0d].lkup_hit", tname, i), 128'(lkup_hit), 128'(vecs[i].e_hit));
      chk($sformatf("%s[%0d].lkup_data", tname, i), lkup_data, vecs[i].e_ldata);
      if (vecs[i].e_req) begin
        chk($sformatf("%s[%0d].mem_addr", tname, i), 128'(mem_addr), 128'(vecs[i].e_maddr));
        chk($sformatf("%s[%0d].mem_data", tname, i), mem_data, vecs[i].e_mdata);
      end
      step();
    end
    vecs.delete();
  endtask

  initial begin
    logic [31:0] rst_addrs[3];
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // single line: reset state, 2-cycle request latency, hold until ack, empty after
    add_vec(0, 0, 0, 32'h1040, 0,   0, 0, 1, 0, 0, 0,   0, 0);
    add_vec(1, 32'h1040, D1, 32'h1040, 0,   1, 0, 1, 0, 0, 0,   0, 0);
    add_vec(0, 0, 0, 32'h1040, 0,   0, 0, 0, 0, 0, 0,   1, D1);
    add_vec(0, 0, 0, 32'h1040, 0,   0, 0, 0, 1, 32'h1040, D1,   1, D1);
    add_vec(0, 0, 0, 32'h1040, 0,   0, 0, 0, 1, 32'h1040, D1,   1, D1);
    add_vec(0, 0, 0, 32'h1040, 1,   0, 0, 0, 1, 32'h1040, D1,   1, D1);
    add_vec(0, 0, 0, 32'h1040, 0,   0, 0, 1, 0, 0, 0,   0, 0);
    run_vecs("single");

    // fill to full, 5th push refused in the pop cycle and accepted the cycle after, FIFO order
    add_vec(1, 32'h100, B1, 0, 0,   1, 0, 1, 0, 0, 0,   0, 0);
    add_vec(1, 32'h200, B2, 0, 0,   1, 0, 0, 0, 0, 0,   0, 0);
    add_vec(1, 32'h300, B3, 0, 0,   1, 0, 0, 1, 32'h100, B1,   0, 0);
    add_vec(1, 32'h400, B4, 0, 0,   1, 0, 0, 1, 32'h100, B1,   0, 0);
    add_vec(1, 32'h500, B5, 0, 1,   0, 1, 0, 1, 32'h100, B1,   0, 0);
    add_vec(1, 32'h500, B5, 0, 0,   1, 0, 0, 0, 0, 0,   0, 0);
    add_vec(0, 0, 0, 0, 1,          0, 1, 0, 1, 32'h200, B2,   0, 0);
    add_vec(0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0,   0, 0);
    add_vec(0, 0, 0, 0, 1,          0, 0, 0, 1, 32'h300, B3,   0, 0);
    add_vec(0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0,   0, 0);
    add_vec(0, 0, 0, 0, 1,          0, 0, 0, 1, 32'h400, B4,   0, 0);
    add_vec(0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0,   0, 0);
    add_vec(0, 0, 0, 0, 1,          0, 0, 0, 1, 32'h500, B5,   0, 0);
    add_vec(0, 0, 0, 0, 0,          0, 0, 1, 0, 0, 0,   0, 0);
    run_vecs("full");

    // merge into a non-head entry while the head is in flight
    drive(1'b1, 32'h2000, C1, '0, 1'b0); #1; chk("merge.push1_ack", 128'(wb_ack), 128'(1)); step();
    drive(1'b1, 32'h3000, C2, '0, 1'b0); #1; chk("merge.push2_ack", 128'(wb_ack), 128'(1)); step();
    drive(1'b1, 32'h3008, C3, '0, 1'b0); #1;
    chk("merge.merge_ack", 128'(wb_ack), 128'(1));
    chk("merge.head_addr", 128'(mem_addr), 128'(32'h2000));
    step();
    drive(1'b0, '0, '0, 32'h300C, 1'b1); #1;
    chk("merge.lkup_hit", 128'(lkup_hit), 128'(1));
    chk("merge.lkup_data", lkup_data, C3);
    chk("merge.head_data", mem_data, C1);
    step();
    drive(1'b0, '0, '0, '0, 1'b0); #1;
    chk("merge.gap_req", 128'(mem_req), 128'(0));
    step();
    drive(1'b0, '0, '0, '0, 1'b1); #1;
    chk("merge.second_req", 128'(mem_req), 128'(1));
    chk("merge.second_addr", 128'(mem_addr), 128'(32'h3000));
    chk("merge.second_data", mem_data, C3);
    step();
    drive(1'b0, '0, '0, '0, 1'b0); #1;
    chk("merge.empty_after", 128'(empty), 128'(1));

    // re-push of the in-flight head allocates a new entry; memory sees old then new
    drive(1'b1, 32'h6000, E1, '0, 1'b0); #1; chk("repush.first_ack", 128'(wb_ack), 128'(1)); step();
    drive(1'b0, '0, '0, '0, 1'b0); step();
    drive(1'b1, 32'h6000, E2, 32'h6000, 1'b0); #1;
    chk("repush.second_ack", 128'(wb_ack), 128'(1));
    chk("repush.req", 128'(mem_req), 128'(1));
    chk("repush.lkup_prewrite", lkup_data, E1);
    step();
    drive(1'b0, '0, '0, 32'h6000, 1'b1); #1;
    chk("repush.lkup_hit", 128'(lkup_hit), 128'(1));
    chk("repush.lkup_newest", lkup_data, E2);
    chk("repush.mem_old", mem_data, E1);
    step();
    drive(1'b0, '0, '0, '0, 1'b0); #1;
    chk("repush.gap_req", 128'(mem_req), 128'(0));
    step();
    drive(1'b0, '0, '0, '0, 1'b1); #1;
    chk("repush.mem_addr2", 128'(mem_addr), 128'(32'h6000));
    chk("repush.mem_new", mem_data, E2);
    step();
    drive(1'b0, '0, '0, '0, 1'b0); #1;
    chk("repush.empty_after", 128'(empty), 128'(1));

    // same-cycle push is invisible to lookup
    drive(1'b1, 32'h5000, F5, 32'h5000, 1'b0); #1;
    chk("samecyc.hit_now", 128'(lkup_hit), 128'(0));
    chk("samecyc.data_now", lkup_data, 128'(0));
    step();
    drive(1'b0, '0, '0, 32'h5000, 1'b0); #1;
    chk("samecyc.hit_next", 128'(lkup_hit), 128'(1));
    chk("samecyc.data_next", lkup_data, F5);
    step();
    drive(1'b0, '0, '0, '0, 1'b1); #1;
    chk("samecyc.req", 128'(mem_req), 128'(1));
    step();
    drive(1'b0, '0, '0, '0, 1'b0); #1;
    chk("samecyc.empty_after", 128'(empty), 128'(1));

    // reset mid-drain discards everything
    rst_addrs[0] = 32'h7000;
    rst_addrs[1] = 32'h7100;
    rst_addrs[2] = 32'h7200;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rst_addrs[i], G1, '0, 1'b0);
      step();
    end
    drive(1'b0, '0, '0, 32'h7000, 1'b0); #1;
    chk("rst.pre_req", 128'(mem_req), 128'(1));
    chk("rst.pre_hit", 128'(lkup_hit), 128'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst.req", 128'(mem_req), 128'(0));
    chk("rst.empty", 128'(empty), 128'(1));
    chk("rst.full", 128'(full), 128'(0));
    for (int i = 0; i < 3; i++) begin
      lkup_addr = rst_addrs[i];
      #1;
      chk($sformatf("rst.hit_%0h", rst_addrs[i]), 128'(lkup_hit), 128'(0));
      chk($sformatf("rst.data_%0h", rst_addrs[i]), lkup_data, 128'(0));
    end
    step();
    #1;
    chk("rst.req_stays_low", 128'(mem_req), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
